// File: rtl/lock_guard.sv
// Panel-lock consumer: gates key events while locked, blinks the lock LED, beeps on toggle, blanks when idle.
// Latency: every output is registered, one cycle after the inputs; no backpressure, events are simply dropped.
module lock_guard #(
    parameter int unsigned CLK_KHZ    = 50_000,
    parameter int unsigned BLINK_CMAX = 250 * CLK_KHZ,
    parameter int unsigned BEEP_CMAX  = 100 * CLK_KHZ,
    parameter int unsigned IDLE_CMAX  = 10_000 * CLK_KHZ,
    parameter int unsigned NKEY       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lock,
    input  logic            tr_lock,
    input  logic [NKEY-1:0] ev_in,
    output logic [NKEY-1:0] ev_out,
    output logic            led_lck,
    output logic            beep,
    output logic            blank,
    output logic [7:0]      drop_cnt
);

    localparam int BLW = $clog2(BLINK_CMAX + 1);
    localparam int BPW = $clog2(BEEP_CMAX + 1);
    localparam int IDW = $clog2(IDLE_CMAX + 1);

    localparam logic [BLW-1:0] BLINK_LAST = BLW'(BLINK_CMAX - 1);
    localparam logic [BPW-1:0] BEEP_LOAD  = BPW'(BEEP_CMAX);
    localparam logic [IDW-1:0] IDLE_MAX   = IDW'(IDLE_CMAX);

    typedef enum logic {
        UNLK = 1'b0,
        LKD  = 1'b1
    } state_t;

    state_t         state;
    logic [BLW-1:0] blink_cnt;
    logic [BPW-1:0] beep_cnt;
    logic [IDW-1:0] idle_cnt;

    logic           gate;
    logic           any_ev;
    logic           drop_hit;
    logic           entry;
    logic           stay_lkd;
    logic [BPW-1:0] beep_nxt;
    logic [IDW-1:0] idle_nxt;

    // The gate looks at the raw lock level (and tr_lock) so the cycle a lock
    // takes effect never leaks an event, even though the state lags a cycle.
    always_comb begin
        gate     = lock | tr_lock;
        any_ev   = |ev_in;
        drop_hit = gate & any_ev;
        entry    = (state == UNLK) & lock;
        stay_lkd = (state == LKD) & lock;

        beep_nxt = '0;
        if (tr_lock) begin
            beep_nxt = BEEP_LOAD;
        end else if (beep_cnt != '0) begin
            beep_nxt = beep_cnt - BPW'(1);
        end

        idle_nxt = '0;
        if (stay_lkd && !any_ev) begin
            idle_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNLK;
            ev_out    <= '0;
            drop_cnt  <= '0;
            led_lck   <= 1'b0;
            blink_cnt <= '0;
            beep      <= 1'b0;
            beep_cnt  <= '0;
            blank     <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                UNLK: if (lock)  state <= LKD;
                LKD:  if (!lock) state <= UNLK;
                default:         state <= UNLK;
            endcase

            ev_out <= gate ? '0 : ev_in;

            // A drop in the lock-entry cycle starts the new session at 1.
            if (entry) begin
                drop_cnt <= {7'd0, drop_hit};
            end else if (drop_hit && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            if (!lock) begin
                led_lck   <= 1'b0;
                blink_cnt <= '0;
            end else if (entry) begin
                led_lck   <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
                led_lck   <= ~led_lck;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BLW'(1);
            end

            beep_cnt <= beep_nxt;
            beep     <= (beep_nxt != '0);

            idle_cnt <= idle_nxt;
            blank    <= stay_lkd && (idle_nxt == IDLE_MAX);
        end
    end

endmodule

// File: tb/tb_lock_guard.sv
// Directed plus randomized bench for lock_guard against a timestamp-based reference model.
module tb_lock_guard;

    localparam int BL = 4;
    localparam int BP = 3;
    localparam int ID = 10;
    localparam int NEVER = -1_000_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       tr_lock = 1'b0;
    logic [7:0] ev_in = '0;
    logic [7:0] ev_out;
    logic       led_lck;
    logic       beep;
    logic       blank;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: absolute cycle timestamps of the relevant happenings.
    int         n = 0;
    bit         m_locked = 1'b0;
    int         m_entry = 0;
    int         m_last_ev = NEVER;
    int         m_last_tr = NEVER;
    int         m_drop = 0;
    logic [7:0] m_ev = '0;

    lock_guard #(
        .BLINK_CMAX(BL),
        .BEEP_CMAX (BP),
        .IDLE_CMAX (ID),
        .NKEY      (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lock    (lock),
        .tr_lock (tr_lock),
        .ev_in   (ev_in),
        .ev_out  (ev_out),
        .led_lck (led_lck),
        .beep    (beep),
        .blank   (blank),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    // Applies one cycle of inputs, advances the model, compares all outputs.
    task automatic step(input bit r, input bit lk, input bit tr, input logic [7:0] ev);
        bit gate;
        bit dropped;
        int since;
        int quiet_from;
        rst = r;
        lock = lk;
        tr_lock = tr;
        ev_in = ev;
        @(posedge clk);
        #1;
        if (r) begin
            m_locked  = 1'b0;
            m_drop    = 0;
            m_ev      = '0;
            m_last_ev = NEVER;
            m_last_tr = NEVER;
        end else begin
            gate    = lk | tr;
            dropped = gate && (ev != 0);
            m_ev    = gate ? 8'h00 : ev;
            if (lk && !m_locked) begin
                m_entry = n + 1;
                m_drop  = dropped ? 1 : 0;
            end else if (dropped && m_drop < 255) begin
                m_drop = m_drop + 1;
            end
            if (tr) m_last_tr = n;
            if (ev != 0) m_last_ev = n;
            m_locked = lk;
        end
        n++;
        since = n - m_last_tr;
        quiet_from = (m_entry > m_last_ev + 1) ? m_entry : m_last_ev + 1;
        chk("ev_out", ev_out, m_ev);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("beep", beep, (since >= 1 && since <= BP) ? 1 : 0);
        chk("led_lck", led_lck, (m_locked && (((n - m_entry) / BL) % 2 == 0)) ? 1 : 0);
        chk("blank", blank, (m_locked && (n - quiet_from) >= ID) ? 1 : 0);
    endtask

    initial begin
        bit   cur_lock;
        bit   r;
        bit   tr;
        int   dens;
        logic [7:0] ev;

        // Reset state
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("rst_ev_out", ev_out, 8'h00);
        chk("rst_led", led_lck, 1'b0);
        chk("rst_beep", beep, 1'b0);
        chk("rst_blank", blank, 1'b0);
        chk("rst_drop", drop_cnt, 8'h00);

        // Pass-through
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h05);
        chk("pass_ev_out", ev_out, 8'h05);
        step(0, 0, 0, 8'h00);
        chk("pass_ev_clear", ev_out, 8'h00);

        // Lock and drop
        step(0, 0, 1, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'h10);
        chk("lock_drop3", drop_cnt, 8'd3);

        // Blink for 20 cycles, then unlock
        for (int i = 0; i < 20; i++) step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("unlock_led", led_lck, 1'b0);
        chk("unlock_drop_held", drop_cnt, 8'd3);

        // Blank after idle, event wakes, blanks again, unlock clears
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 8'h00);
        chk("blank_on", blank, 1'b1);
        step(0, 1, 0, 8'h40);
        chk("blank_wake", blank, 1'b0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("blank_unlock", blank, 1'b0);

        // Saturation and beep retrigger
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 300; i++) step(0, 1, 0, 8'h81);
        chk("drop_sat", drop_cnt, 8'd255);
        step(0, 1, 1, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);

        // Reset during beep, blink and blank with lock held high
        for (int i = 0; i < 12; i++) step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'h00);
        step(1, 1, 0, 8'h22);
        chk("mid_rst_ev_out", ev_out, 8'h00);
        chk("mid_rst_led", led_lck, 1'b0);
        chk("mid_rst_beep", beep, 1'b0);
        chk("mid_rst_blank", blank, 1'b0);
        chk("mid_rst_drop", drop_cnt, 8'h00);
        step(0, 1, 0, 8'h00);
        chk("post_rst_led", led_lck, 1'b1);
        step(0, 1, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        // Randomized traffic with toggler-style lock behaviour
        cur_lock = 1'b0;
        dens = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) dens = $urandom_range(0, 2);
            r  = ($urandom_range(0, 199) == 0);
            tr = ($urandom_range(0, 39) == 0);
            ev = 8'h00;
            if ((dens == 1 && $urandom_range(0, 7) == 0) || (dens == 2 && $urandom_range(0, 1) == 0))
                ev = 8'($urandom_range(1, 255));
            step(r, cur_lock, tr, ev);
            if (tr && !r) cur_lock = ~cur_lock;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lock_guard.md
# lock_guard

Consumer of the panel lock produced by the long-press lock toggler. Sits between the debounced key/button event pulses and the command logic: while locked it discards user events, blinks the lock LED, sounds a short confirmation beep on every lock toggle, and blanks the display after a period of inactivity. Everything runs in the single system clock domain.

## Interface
Parameters:
- BLINK_CMAX, `c_ms(250)`: lock LED half-period, in clock cycles.
- BEEP_CMAX, `c_ms(100)`: beep pulse length, in cycles.
- IDLE_CMAX, `c_ms(10000)`: number of idle cycles while locked before the display blanks.
- NKEY, 8: number of event lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. It is sampled on the rising edge of clk. This is fixed.
- lock  in  1  lock level from the toggler.
- tr_lock  in  1  one-cycle pulse. It is high the cycle before `lock` inverts.
- ev_in  in  NKEY  one-cycle event pulses, one per key.
- ev_out  out  NKEY  gated events, registered.
- led_lck  out  1  lock LED.
- beep  out  1  buzzer enable.
- blank  out  1  display blank request.
- drop_cnt  out  8  number of dropped event cycles in the current lock session.

## Operation
- State machine with two states, UNLK and LKD, held in a registered state bit.
  - UNLK goes to LKD on any cycle with lock=1.
  - LKD goes to UNLK on any cycle with lock=0.
  - The state reflects `lock` with 1 cycle of delay.
- Gate, sampled on `lock` and not on the state:
  - ev_out <= (lock | tr_lock) ? 0 : ev_in.
  - tr_lock also gates, so the cycle in which a long press completes never leaks an event.
- drop_cnt:
  - Increments by 1 on every cycle where ev_in != 0 and the gate is closed. Multiple bits set in the same cycle count as 1.
  - Saturates at 255; it does not wrap.
  - Cleared to 0 on the UNLK->LKD transition cycle. It holds its value while in UNLK, so software can read the last session's count.
- led_lck:
  - Driven 0 in UNLK.
  - On entry to LKD it is set to 1 and the blink counter is cleared.
  - The blink counter counts 0..BLINK_CMAX-1. When it wraps, led_lck inverts.
- beep:
  - A tr_lock pulse loads the beep counter with BEEP_CMAX. beep is high while the counter is nonzero, and the counter decrements each cycle.
  - A new tr_lock while beeping reloads the counter (retrigger). The beep does not extend beyond BEEP_CMAX from the latest pulse.
- Idle/blank:
  - In UNLK the idle counter is 0 and blank is 0.
  - In LKD the counter increments each cycle with ev_in == 0, saturating at IDLE_CMAX. blank=1 while the counter equals IDLE_CMAX.
  - Any cycle with ev_in != 0 clears the counter, so blank drops on the next cycle.
- Counter widths are $clog2(CMAX+1). All comparisons are unsigned.

## Timing
- Reset values: ev_out=0, led_lck=0, beep=0, blank=0, drop_cnt=0, state=UNLK. All counters are 0.
- Reset mid-beep or mid-blink aborts immediately. rst has priority over every other input.
- ev_in to ev_out latency is 1 cycle.
- Lock LED timing:
  - lock rising at cycle t: state=LKD at t+1, led_lck=1 at t+1.
  - First inversion of led_lck at t+1+BLINK_CMAX.
  - lock falling at cycle u: led_lck=0 at u+1.
- Beep timing: tr_lock at cycle t gives beep=1 for cycles t+1..t+BEEP_CMAX inclusive.
- Blank timing:
  - With continuous idle from LKD entry at t+1, blank=1 from cycle t+1+IDLE_CMAX.
  - An event at cycle v gives blank=0 at v+1.
- Simultaneous events:
  - The lock rise cycle clears drop_cnt. If an event is dropped in that same cycle, the result is drop_cnt=1, not 0.
  - tr_lock together with ev_in gives ev_out=0 and counts one drop, regardless of the current lock level.
- The module contains no combinational path from input to output. All outputs are registered.

## Test plan
Use parameters BLINK_CMAX=4, BEEP_CMAX=3, IDLE_CMAX=10, NKEY=8.
1. Pass-through: lock=0, ev_in=8'h05 for 1 cycle -> ev_out=8'h05 exactly 1 cycle later; drop_cnt=0; beep, blank and led_lck stay 0.
2. Lock and drop: pulse tr_lock, then raise lock; apply 3 events, one of them with ev_in=8'hFF -> ev_out stays 0; drop_cnt=3; beep high for exactly 3 cycles after tr_lock.
3. Blink: hold lock=1 for 20 cycles -> led_lck=1 for 4 cycles, then 0 for 4, repeating; drop lock -> led_lck=0 next cycle.
4. Blank: in LKD with no events -> blank=1 at 10 cycles after entry; one ev_in pulse -> blank=0 next cycle, then blank=1 again 10 idle cycles later; unlock -> blank=0.
5. Saturation/retrigger: 300 dropped event cycles -> drop_cnt=255. tr_lock at t and t+2 -> beep high t+1..t+5 continuously.
6. Reset mid-operation: assert rst during beep, blink and blank -> all outputs 0 on the next edge; drop_cnt=0; state UNLK even if lock=1 during rst. After rst releases, with lock=1, state goes to LKD one cycle later.
